fetch_unit: RTL

Instruction fetch initiator for the filter processor. Drives the 32-bit address into the instruction memory, captures the 16-bit word it returns, and hands instructions to decode with a valid flag, PC tag, stall hold and branch redirect. Sits between the instruction memory and the decode stage. It owns the program counter and the end-of-program halt.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, holds through memory self-init,
// and hands captured words to decode with stall hold, branch squash and end-of-program halt.
module fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int INST_W      = 16,
  parameter int RESET_PC    = 0,
  parameter int LAST_ADDR   = 255,
  parameter int INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [INST_W-1:0] i_inst,
  output logic [31:0]       o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_valid,
  output logic              o_halted
);

  // One spare count value so the counter can step past the last INIT cycle.
  localparam int CNT_W = $clog2(INIT_CYCLES + 2);
  localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              valid;
  } dec_out_t;

  localparam dec_out_t OUT_RST = '{inst: {INST_W{1'b1}}, pc: '0, valid: 1'b0};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  dec_out_t          out_q, out_d;
  logic              halted_q, halted_d;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      pc_q     <= RST_PC;
      out_q    <= OUT_RST;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    out_d    = out_q;
    halted_d = halted_q;
    case (state_q)
      // Memory is still initialising: stall and branch have no effect here.
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INIT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (i_branch_taken) begin
          // Word arriving from the old PC is squashed.
          pc_d        = i_branch_target;
          out_d.valid = 1'b0;
        end else if (!i_stall) begin
          out_d.inst  = i_inst;
          out_d.pc    = pc_q;
          out_d.valid = 1'b1;
          if (pc_q == LAST_PC) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      // Last word stays offered until decode stops stalling.
      S_HALT: if (!i_stall) out_d.valid = 1'b0;
      default: state_d = S_INIT;
    endcase
  end

  assign o_pc      = 32'(pc_q);
  assign o_inst    = out_q.inst;
  assign o_inst_pc = out_q.pc;
  assign o_valid   = out_q.valid;
  assign o_halted  = halted_q;

endmodule
